// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter: controller states and ALU op encodings.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one priority pointer, combinational winner.
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic win,
  output logic any
);

  // ptr == 0 gives requester 0 priority on a tie.
  logic ptr;

  always_comb begin
    any = req0 | req1;
    win = (req0 && req1) ? ptr : req1;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance && any) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU: grant, execute, report done.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [1:0]   func0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic [1:0]   func1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_func,
  input  logic [N-1:0] alu_y,
  input  logic [3:0]   alu_flags,
  output logic [N-1:0] y,
  output logic [3:0]   flags,
  output logic         done0,
  output logic         done1,
  output logic         busy
);

  state_t state;
  logic   win;
  logic   any;
  logic   advance;

  // The pointer only moves when a grant is actually issued from IDLE.
  assign advance = (state == IDLE);
  assign busy    = (state != IDLE);

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .advance (advance),
    .win     (win),
    .any     (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= ALU_ADD;
      y        <= '0;
      flags    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            alu_a    <= win ? a1 : a0;
            alu_b    <= win ? b1 : b0;
            alu_func <= win ? func1 : func0;
            gnt0     <= ~win;
            gnt1     <= win;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // Operands were frozen at grant; the ALU output reflects them now.
          y     <= alu_y;
          flags <= alu_flags;
          done0 <= gnt0;
          done1 <= gnt1;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an external ALU model and a result scoreboard.
module tb_alu_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [N-1:0] a0, b0, a1, b1;
  logic [1:0]   func0, func1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [N-1:0] alu_a, alu_b, alu_y, y;
  logic [1:0]   alu_func;
  logic [3:0]   alu_flags, flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           who;
    logic [N-1:0] y;
    logic [3:0]   f;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .func0     (func0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .func1     (func1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .alu_y     (alu_y),
    .alu_flags (alu_flags),
    .y         (y),
    .flags     (flags),
    .done0     (done0),
    .done1     (done1),
    .busy      (busy)
  );

  // External shared ALU; flags are {N,Z,C,V}, C is carry for add and borrow for sub.
  always_comb begin
    logic [N:0] wide;
    logic       c, v;
    wide = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (alu_func)
      2'b00: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        c    = wide[N];
        v    = (alu_a[N-1] == alu_b[N-1]) && (wide[N-1] != alu_a[N-1]);
      end
      2'b01: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        c    = (alu_a < alu_b);
        v    = (alu_a[N-1] != alu_b[N-1]) && (wide[N-1] != alu_a[N-1]);
      end
      2'b10:   wide = {1'b0, alu_a & alu_b};
      default: wide = {1'b0, alu_a | alu_b};
    endcase
    alu_y = wide[N-1:0];
    if (alu_func[1]) alu_flags = 4'b0000;
    else             alu_flags = {alu_y[N-1], alu_y == '0, c, v};
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks exclusivity each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_exclusive", {1'b0, gnt0 & gnt1}, 2'b00);
      check("done_exclusive", {1'b0, done0 & done1}, 2'b00);
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_who", {done0, done1}, e.who ? 2'b01 : 2'b10);
          check("result_y", y, e.y);
          check("result_flags", flags, e.f);
        end
      end
    end
  end

  task automatic drive(input bit who, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [1:0] f);
    if (!who) begin a0 = a; b0 = b; func0 = f; req0 = 1'b1; end
    else      begin a1 = a; b1 = b; func1 = f; req1 = 1'b1; end
  endtask

  task automatic do_op(input bit who, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [1:0] f, input logic [N-1:0] ey, input logic [3:0] ef,
                       input bit scramble);
    @(negedge clk);
    drive(who, a, b, f);
    sb.push_back('{who, ey, ef});
    @(negedge clk);
    check("grant", {gnt0, gnt1}, who ? 2'b01 : 2'b10);
    check("busy_exec", busy, 1'b1);
    check("alu_a_latched", alu_a, a);
    check("alu_func_latched", alu_func, f);
    if (scramble) begin
      if (!who) a0 = ~a; else a1 = ~a;
    end
    @(negedge clk);
    check("done_latency", {done0, done1}, who ? 2'b01 : 2'b10);
    check("gnt_cleared", {gnt0, gnt1}, 2'b00);
    check("alu_a_stable", alu_a, a);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("done_pulse", {done0, done1}, 2'b00);
    check("back_idle", busy, 1'b0);
  endtask

  task automatic check_reset_state(input string name);
    check(name, {gnt0, gnt1, done0, done1, busy, alu_a, alu_b, alu_func, y, flags}, '0);
  endtask

  initial begin
    bit order[$];
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; func0 = 2'b00; func1 = 2'b00;
    #1;
    check_reset_state("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_req", {busy, gnt0, gnt1}, 3'b000);

    do_op(1'b0, 32'd5, 32'd3, 2'b00, 32'd8, 4'b0000, 1'b0);
    do_op(1'b1, 32'd3, 32'd3, 2'b01, 32'd0, 4'b0100, 1'b0);
    do_op(1'b1, 32'd2, 32'd3, 2'b01, 32'hFFFF_FFFF, 4'b1010, 1'b0);
    do_op(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'hF000_F000, 4'b0000, 1'b0);
    do_op(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b11, 32'hFFF0_FFF0, 4'b0000, 1'b0);
    do_op(1'b1, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 4'b1001, 1'b0);
    do_op(1'b0, 32'd100, 32'd1, 2'b01, 32'd99, 4'b0000, 1'b1);

    // Reset in EXEC after granting requester 0: no done, pointer back to 0.
    @(negedge clk);
    drive(1'b0, 32'd1, 32'd1, 2'b00);
    @(negedge clk);
    check("midop_grant", {gnt0, gnt1}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check_reset_state("midop_reset_outputs");
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Continuous contention: grants must alternate starting with requester 0.
    a0 = 32'd10; b0 = 32'd4; func0 = 2'b01;
    a1 = 32'hFFFF_FFFF; b1 = 32'd1; func1 = 2'b00;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, 32'd6, 4'b0000});
      sb.push_back('{1'b1, 32'd0, 4'b0110});
    end
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) order.push_back(gnt1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("contention_grants", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      check("contention_order", order[i], i % 2);

    do_op(1'b1, 32'd20, 32'd22, 2'b00, 32'd42, 4'b0000, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: N, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request; held high until done0.
REQ-005 a0, b0  input  N each  requester 0 operands.
REQ-006 func0  input  2  requester 0 op: 00 add, 01 sub, 10 and, 11 or.
REQ-007 req1, a1, b1, func1  input  1/N/N/2  requester 1 equivalents.
REQ-008 gnt0, gnt1  output  1 each  registered grant; one-hot or zero.
REQ-009 alu_a, alu_b  output  N each  registered operands driven to the shared ALU.
REQ-010 alu_func  output  2  registered ALU op select.
REQ-011 alu_y  input  N  shared ALU result, combinational from alu_a/alu_b/alu_func.
REQ-012 alu_flags  input  4  shared ALU flags {N,Z,C,V}; 0000 for and/or.
REQ-013 y  output  N  captured result; holds until next capture.
REQ-014 flags  output  4  captured flags; holds until next capture.
REQ-015 done0, done1  output  1 each  one-cycle pulse: y/flags valid for that requester.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-018 IDLE: if req0 or req1 high at an edge, winner's a/b/func SHALL load into alu_a/alu_b/alu_func, its gnt SHALL assert, state -> EXEC; else stay IDLE, registers unchanged.
REQ-019 EXEC: at next edge, alu_y/alu_flags SHALL load into y/flags, granted requester's done SHALL assert, gnt SHALL clear, state -> DONE.
REQ-020 DONE: at next edge, done SHALL clear, state -> IDLE unconditionally; requests present in DONE SHALL be ignored.
REQ-021 Latency: request sampled at edge k -> done high during cycle after edge k+1; max throughput one op per 3 cycles.
REQ-022 Arbitration SHALL be round-robin with one priority pointer; pointer SHALL point to requester 0 after reset.
REQ-023 Single request SHALL win regardless of pointer; simultaneous requests SHALL grant the pointed requester.
REQ-024 After each grant the pointer SHALL move to the non-granted requester.
REQ-025 Request changes or drops during EXEC SHALL NOT alter the in-flight operation; alu_a/alu_b/alu_func stay stable EXEC through DONE.
REQ-026 y and flags SHALL be passed through unmodified from ALU (no width change, no flag recomputation).
REQ-027 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.

Reset
REQ-028 On rst high, immediately and independent of clk: state IDLE, pointer 0, gnt0/gnt1/done0/done1/busy 0, alu_a/alu_b/y 0, alu_func 00, flags 0000.
REQ-029 Reset during EXEC or DONE SHALL abort the operation with no done pulse; requester must re-request.
REQ-030 First arbitration after reset release SHALL occur at the first rising edge with rst low.

Structure
REQ-031 Shared package alu_ctrl_pkg SHALL hold the state enum (IDLE, EXEC, DONE) and func constants ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_OR=11.
REQ-032 One sub-module rr_arbiter_2 SHALL hold the priority pointer and produce the combinational winner from req0, req1 and an advance strobe.
REQ-033 The ALU instance SHALL stay outside this block; connection only via alu_a/alu_b/alu_func/alu_y/alu_flags.

Verification
REQ-034 Single add: req0, a0=5, b0=3, func0=00 -> gnt0 next cycle, done0 one cycle later with y=8, flags=0000, back to IDLE one cycle after.
REQ-035 Sub to zero/negative: req1, a1=3, b1=3, func1=01 -> y=0, Z set; then a1=2, b1=3 -> y=32'hFFFF_FFFF, N set.
REQ-036 Contention: req0 and req1 high continuously after reset -> grants alternate 0,1,0,1; never both gnt high.
REQ-037 Logic ops: req0 func0=10, a0=32'hF0F0_F0F0, b0=32'hFF00_FF00 -> y=32'hF000_F000, flags=0000; func0=11 -> y=32'hFFF0_FFF0.
REQ-038 Reset mid-op: assert rst during EXEC -> all outputs zero immediately, no done pulse, pointer 0; next req1 alone granted.
REQ-039 Operand change in EXEC: change a0 after grant -> y reflects value latched at grant.
